// File: rtl/code_detector_pkg.sv
// Shared types for the four-colour combination-lock detector: FSM states,
// colour encodings ({Red,Green,Blue}) and the per-step compare result.
package code_detector_pkg;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_C1     = 3'd2,
        ST_C2     = 3'd3,
        ST_C3     = 3'd4,
        ST_UNLOCK = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        STEP_IDLE  = 2'd0,
        STEP_MATCH = 2'd1,
        STEP_MISS  = 2'd2
    } step_t;

    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_NONE  = 3'b000;

endpackage

// File: rtl/code_step_cmp.sv
// Classifies one sampled colour against the expected code colour for the
// current step: idle (no button), match (exact), or mismatch.
module code_step_cmp
    import code_detector_pkg::*;
(
    input  logic [2:0] col,
    input  logic [2:0] code,
    output step_t      result
);

    // Idle wins over match so a 000 code step can never advance.
    always_comb begin
        result = STEP_MISS;
        if (col == COL_NONE) begin
            result = STEP_IDLE;
        end else if (col == code) begin
            result = STEP_MATCH;
        end
    end

endmodule

// File: rtl/code_detector.sv
// Four-colour combination-lock detector. Moore FSM armed by a rising edge of
// Start; U is registered and high only in the UNLOCK state.
module code_detector
    import code_detector_pkg::*;
#(
    parameter logic [2:0] CODE1 = 3'b100,
    parameter logic [2:0] CODE2 = 3'b001,
    parameter logic [2:0] CODE3 = 3'b010,
    parameter logic [2:0] CODE4 = 3'b100
) (
    input  logic   Clk,
    input  logic   Rst,
    input  logic   Start,
    input  logic   Red,
    input  logic   Green,
    input  logic   Blue,
    output logic   U,
    output state_t dbg_state
);

    state_t     state;
    logic       start_q;
    logic       start_rise;
    logic [2:0] col;
    logic [2:0] cur_code;
    step_t      step;

    assign col        = {Red, Green, Blue};
    assign start_rise = Start & ~start_q;
    assign dbg_state  = state;

    // One comparator shared by all steps; the state selects the code colour.
    always_comb begin
        cur_code = COL_NONE;
        case (state)
            ST_ARMED: cur_code = CODE1;
            ST_C1:    cur_code = CODE2;
            ST_C2:    cur_code = CODE3;
            ST_C3:    cur_code = CODE4;
            default:  cur_code = COL_NONE;
        endcase
    end

    code_step_cmp u_cmp (
        .col    (col),
        .code   (cur_code),
        .result (step)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= ST_WAIT;
            U       <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= Start;
            U       <= 1'b0;
            if (!Start) begin
                state <= ST_WAIT;
            end else if (start_rise) begin
                state <= ST_ARMED;
            end else begin
                case (state)
                    ST_WAIT: state <= ST_WAIT;
                    ST_ARMED: begin
                        if (step == STEP_MATCH)     state <= ST_C1;
                        else if (step == STEP_MISS) state <= ST_ERROR;
                    end
                    ST_C1: begin
                        if (step == STEP_MATCH)     state <= ST_C2;
                        else if (step == STEP_MISS) state <= ST_ERROR;
                    end
                    ST_C2: begin
                        if (step == STEP_MATCH)     state <= ST_C3;
                        else if (step == STEP_MISS) state <= ST_ERROR;
                    end
                    ST_C3: begin
                        if (step == STEP_MATCH) begin
                            state <= ST_UNLOCK;
                            U     <= 1'b1;
                        end else if (step == STEP_MISS) begin
                            state <= ST_ERROR;
                        end
                    end
                    ST_UNLOCK: begin
                        state <= ST_UNLOCK;
                        U     <= 1'b1;
                    end
                    ST_ERROR: state <= ST_ERROR;
                    default:  state <= ST_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_code_detector.sv
// Directed bench for code_detector: reset, correct code, full 4096-sequence
// sweep, wrong/idle colours, restart/abort and asynchronous reset mid-entry.
module tb_code_detector;
    import code_detector_pkg::*;

    logic   Clk;
    logic   Rst;
    logic   Start;
    logic   Red;
    logic   Green;
    logic   Blue;
    logic   U;
    state_t dbg_state;

    int total;
    int bad;

    code_detector dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Red       (Red),
        .Green     (Green),
        .Blue      (Blue),
        .U         (U),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] c);
        Start = st;
        {Red, Green, Blue} = c;
    endtask

    task automatic arm(input logic [2:0] c_at_arm);
        drive(1'b0, 3'b000);
        tick();
        drive(1'b1, c_at_arm);
        tick();
    endtask

    task automatic run_code(input logic [2:0] a, input logic [2:0] b,
                            input logic [2:0] c, input logic [2:0] d);
        arm(3'b000);
        drive(1'b1, a); tick();
        drive(1'b1, b); tick();
        drive(1'b1, c); tick();
        drive(1'b1, d); tick();
    endtask

    initial begin
        logic [11:0] v;
        total = 0;
        bad   = 0;

        // Reset with arbitrary inputs
        Rst = 1'b0;
        drive(1'b1, 3'b111);
        tick();
        tick();
        check("rst_u", {7'd0, U}, 8'd0);
        check("rst_state", {5'd0, dbg_state}, {5'd0, ST_WAIT});
        drive(1'b0, 3'b000);
        #2 Rst = 1'b1;
        tick();
        check("rel_u", {7'd0, U}, 8'd0);
        check("rel_state", {5'd0, dbg_state}, {5'd0, ST_WAIT});

        // Correct code with latency checks
        arm(3'b000);
        check("arm_state", {5'd0, dbg_state}, {5'd0, ST_ARMED});
        drive(1'b1, COL_RED);   tick();
        check("c1_state", {5'd0, dbg_state}, {5'd0, ST_C1});
        drive(1'b1, COL_BLUE);  tick();
        drive(1'b1, COL_GREEN); tick();
        check("c3_state", {5'd0, dbg_state}, {5'd0, ST_C3});
        check("c3_u", {7'd0, U}, 8'd0);
        drive(1'b1, COL_RED);   tick();
        check("unlock_u", {7'd0, U}, 8'd1);
        check("unlock_state", {5'd0, dbg_state}, {5'd0, ST_UNLOCK});
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)));
            tick();
            check("unlock_hold", {7'd0, U}, 8'd1);
        end
        drive(1'b0, 3'b000);
        tick();
        check("drop_u", {7'd0, U}, 8'd0);
        check("drop_state", {5'd0, dbg_state}, {5'd0, ST_WAIT});

        // Exhaustive sweep of all four-colour sequences
        for (int s = 0; s < 4096; s++) begin
            v = 12'(s);
            run_code(v[11:9], v[8:6], v[5:3], v[2:0]);
            check("sweep", {7'd0, U}, {7'd0, v == 12'b100_001_010_100});
        end

        // Wrong second colour, correct tail follows
        run_code(COL_RED, COL_GREEN, COL_GREEN, COL_RED);
        check("wrong_u", {7'd0, U}, 8'd0);
        check("wrong_state", {5'd0, dbg_state}, {5'd0, ST_ERROR});

        // Idle cycles between correct colours
        arm(3'b000);
        drive(1'b1, COL_RED);   tick();
        drive(1'b1, COL_NONE);  tick();
        drive(1'b1, COL_BLUE);  tick();
        drive(1'b1, COL_NONE);  tick();
        drive(1'b1, COL_NONE);  tick();
        check("idle_hold", {5'd0, dbg_state}, {5'd0, ST_C2});
        drive(1'b1, COL_GREEN); tick();
        drive(1'b1, COL_RED);   tick();
        check("idle_u", {7'd0, U}, 8'd1);

        // Colour present on the arming edge is ignored
        run_code(COL_RED, COL_BLUE, COL_GREEN, COL_RED);
        arm(COL_RED);
        check("arm_ign_state", {5'd0, dbg_state}, {5'd0, ST_ARMED});
        drive(1'b1, COL_RED);   tick();
        drive(1'b1, COL_BLUE);  tick();
        drive(1'b1, COL_GREEN); tick();
        drive(1'b1, COL_RED);   tick();
        check("arm_ign_u", {7'd0, U}, 8'd1);

        // Abort after two correct colours, then full code
        arm(3'b000);
        drive(1'b1, COL_RED);  tick();
        drive(1'b1, COL_BLUE); tick();
        drive(1'b0, COL_GREEN); tick();
        check("abort_state", {5'd0, dbg_state}, {5'd0, ST_WAIT});
        check("abort_u", {7'd0, U}, 8'd0);
        run_code(COL_RED, COL_BLUE, COL_GREEN, COL_RED);
        check("reentry_u", {7'd0, U}, 8'd1);

        // Multi-press at the third step
        run_code(COL_RED, COL_BLUE, 3'b110, COL_RED);
        check("multi_u", {7'd0, U}, 8'd0);
        check("multi_state", {5'd0, dbg_state}, {5'd0, ST_ERROR});

        // Asynchronous reset while in C2
        arm(3'b000);
        drive(1'b1, COL_RED);  tick();
        drive(1'b1, COL_BLUE); tick();
        check("pre_rst_state", {5'd0, dbg_state}, {5'd0, ST_C2});
        #1 Rst = 1'b0;
        #1;
        check("async_u", {7'd0, U}, 8'd0);
        check("async_state", {5'd0, dbg_state}, {5'd0, ST_WAIT});
        drive(1'b0, 3'b000);
        tick();
        Rst = 1'b1;
        run_code(COL_RED, COL_BLUE, COL_GREEN, COL_RED);
        check("post_rst_u", {7'd0, U}, 8'd1);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_detector.md
Name: code_detector

Overview:
- Four-colour combination-lock detector.
- A user arms it with Start, then presses four colour buttons, one per clock cycle: Red, Green or Blue.
- The unlock output U asserts when the four sampled colours match the programmed code in order.
- Standalone control block; it drives a lock actuator / status flag.

Parameters:
- CODE1, 3'b100, first colour of the code as {Red,Green,Blue} (default Red)
- CODE2, 3'b001, second colour (default Blue)
- CODE3, 3'b010, third colour (default Green)
- CODE4, 3'b100, fourth colour (default Red)

Ports:
- Clk  input  1  system clock; all state changes on its rising edge
- Rst  input  1  reset, asynchronous, active-low
- Start  input  1  arm/enable level; held high for the whole entry
- Red  input  1  red button
- Green  input  1  green button
- Blue  input  1  blue button
- U  output  1  unlock indication

Behaviour:
- One clock; reset is asynchronous and active-low. While Rst=0: state=WAIT, U=0, start_q=0.
- Inputs are sampled on the rising edge of Clk.
- col = {Red,Green,Blue}. start_q is a register holding Start from the previous edge.
- start_rise = Start & ~start_q.

Moore FSM. States: WAIT, ARMED, C1, C2, C3, UNLOCK, ERROR.
- U = 1 only in UNLOCK.
- U is decoded from the state register with no combinational path from the inputs.

Priority 1 (any state, next edge): Start=0 -> WAIT (abort/clear).

Priority 2 (any state, next edge): start_rise=1 -> ARMED (restart).
- Colours sampled on this edge are ignored.

Otherwise, with Start=1:
- WAIT: stay. Entry requires a new rising edge of Start.
- ARMED: col==CODE1 -> C1; col==000 -> stay; otherwise -> ERROR.
- C1: col==CODE2 -> C2; 000 -> stay; otherwise -> ERROR.
- C2: col==CODE3 -> C3; 000 -> stay; otherwise -> ERROR.
- C3: col==CODE4 -> UNLOCK; 000 -> stay; otherwise -> ERROR.
- UNLOCK: stay; U held high for as long as Start stays high. Colours are ignored.
- ERROR: stay, with U=0, until Start drops.

Comparison rules:
- Exact 3-bit compare. Multiple buttons pressed at once never match a one-hot code, so it goes to ERROR.
- If a CODEn parameter is 000, that step can never advance. This is legal but yields an unopenable lock.

Latency:
- Start rises and is sampled at edge E1 -> ARMED.
- Colours sampled at E2..E5 -> UNLOCK after E5.
- U is high from just after E5.

Reset mid-sequence: immediate WAIT, U=0. After release, a fresh Start rising edge is needed.

Decomposition:
- Shared package: the state enum (WAIT..ERROR) and the colour constants COL_RED=3'b100, COL_GREEN=3'b010, COL_BLUE=3'b001, COL_NONE=3'b000.
- Single module. An optional sub-module, code_step_cmp, returns match / idle / mismatch for one step. It is instantiated per step or muxed by state.

Test Plan:
- Reset: Rst=0 with arbitrary inputs -> U=0, state WAIT. Release with Start=0 -> U stays 0.
- Correct code: Start 0->1 with col=000, then one cycle each of 100, 001, 010, 100 -> U=1 after the 5th edge. U stays 1 while Start=1, and drops to 0 one edge after Start=0.
- Exhaustive sweep: all 4096 four-colour sequences, each armed by a fresh Start rise and checked after the 5th edge -> U=1 only for 100_001_010_100.
- Wrong/idle colours:
  - 100, 010, ... -> ERROR, U=0 even if a correct tail follows.
  - 000 cycles inserted between correct colours -> the step holds and a later unlock still succeeds.
- Restart/abort:
  - Drop Start to 0 after two correct colours -> WAIT.
  - Re-raise Start and enter the full code -> U=1.
  - Multi-press 110 at any step -> ERROR.
- Async reset mid-entry: assert Rst=0 between edges while in C2 -> U=0 and WAIT immediately, without waiting for a clock edge.
